// File: rtl/instruction_fetch_controller_pkg.sv
// Shared types for the MIPS instruction fetch path: FSM states, FIFO entry layout
// and the PC legality check used at issue time.
package mips_fetch_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A PC may only be issued when word aligned and within the last legal word.
    function automatic logic pc_illegal(input logic [31:0] pc, input logic [31:0] last_word);
        logic misaligned;
        logic beyond;
        misaligned = (pc[1:0] != 2'b00);
        beyond     = (pc > last_word);
        return misaligned || beyond;
    endfunction

endpackage

// File: rtl/instruction_fetch_controller_fifo.sv
// Two-entry skid FIFO of fetch entries. Entry 0 is always the head, so the
// decode-facing outputs come straight from flops.
module fetch_skid_fifo
    import mips_fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic         valid,
    output logic [1:0]   count
);

    fetch_entry_t ent0_q, ent0_d;
    fetch_entry_t ent1_q, ent1_d;
    logic [1:0]   count_q, count_d;
    logic         valid_q, valid_d;
    logic         pop_ok_s;
    logic         push_ok_s;

    // Next-state for the shift-style storage: pops move entry 1 into the head slot.
    always_comb begin
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        count_d   = count_q;
        pop_ok_s  = pop && (count_q != 2'd0);
        push_ok_s = push && ((count_q != 2'd2) || pop_ok_s);
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = push_entry;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_entry;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_d = push_entry;
                    end else begin
                        ent1_d = push_entry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
        valid_d = (count_d != 2'd0);
    end

    // Storage and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign head  = ent0_q;
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_controller.sv
// Fetch sequencer: owns the PC, issues one word read per cycle to a 1-cycle
// registered instruction memory and hands returned words to decode.
module instruction_fetch_controller
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_BYTES  = 512,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_WORD  = 32'(MEM_BYTES - INSTR_BYTES);
    localparam logic [31:0] PC_STEP    = 32'(INSTR_BYTES);
    localparam logic [2:0]  SLOT_LIMIT = 3'(FIFO_DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  tag_q, tag_d;
    logic         fault_q, fault_d;
    logic [31:0]  fetch_count_q, fetch_count_d;

    logic         pop_s;
    logic         redirect_s;
    logic         issue_req_s;
    logic         push_s;
    logic         fifo_pop_s;
    logic [2:0]   occupancy_s;
    fetch_entry_t push_entry_s;
    fetch_entry_t head_s;
    logic         fifo_valid_s;
    logic [1:0]   fifo_count_s;

    // Issue, redirect, fault and transfer accounting.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        tag_d         = tag_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        pop_s       = fifo_valid_s && out_ready;
        redirect_s  = redirect_valid && (state_q == RUN);
        occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_q};
        issue_req_s = (state_q == RUN) && !redirect_s && ((occupancy_s < SLOT_LIMIT) || pop_s);
        // A redirect squashes the word returning this cycle along with the buffer.
        push_s      = inflight_q && !redirect_s;
        fifo_pop_s  = pop_s && !redirect_s;

        if (fifo_pop_s) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end

        case (state_q)
            RUN: begin
                if (redirect_s) begin
                    fetch_pc_d = redirect_pc;
                end else if (issue_req_s) begin
                    if (pc_illegal(fetch_pc_q, LAST_WORD)) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        inflight_d = 1'b1;
                        tag_d      = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                    end
                end else begin
                    inflight_d = 1'b0;
                end
            end
            FAULT: begin
                inflight_d = 1'b0;
            end
            default: begin
                state_d = FAULT;
                fault_d = 1'b1;
            end
        endcase
    end

    // Control and PC registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            tag_q         <= 32'h0000_0000;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            tag_q         <= tag_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign push_entry_s = '{pc: tag_q, instr: imem_data};

    fetch_skid_fifo u_skid (
        .clock      (clock),
        .reset      (reset),
        .push       (push_s),
        .pop        (fifo_pop_s),
        .flush      (redirect_s),
        .push_entry (push_entry_s),
        .head       (head_s),
        .valid      (fifo_valid_s),
        .count      (fifo_count_s)
    );

    assign imem_addr   = fetch_pc_q;
    assign out_valid   = fifo_valid_s;
    assign out_instr   = head_s.instr;
    assign out_pc      = head_s.pc;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule
